// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding an 8N1 UART serializer; frames go out back-to-back while
// the queue holds data, and pushes into a full queue are dropped and flagged.
module uart_tx_queue #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  transmit,
    input  logic [7:0]            tx_byte,
    output logic                  tx,
    output logic                  is_transmitting,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                DEPTH      = 2 ** DEPTH_LOG2;
    localparam int                BW         = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]     BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ZERO = {(DEPTH_LOG2 + 1){1'b0}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [7:0]              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_overflow;
    logic [BW-1:0]           r_baud;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic                    w_baud_done;
    logic                    w_not_empty;
    logic                    w_push;
    logic                    w_pop;

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_not_empty = (r_count != COUNT_ZERO);
    assign full        = (r_count == COUNT_FULL);
    assign count       = r_count;
    assign overflow    = r_overflow;
    // Full is judged on the pre-edge count, so a pop on the same edge never rescues a push.
    assign w_push      = transmit & ~full;
    assign w_pop       = w_not_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_not_empty) w_state_next = S_START; else w_state_next = S_IDLE;
            S_START: if (w_baud_done) w_state_next = S_DATA;  else w_state_next = S_START;
            S_DATA:  if (w_baud_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
                     else w_state_next = S_DATA;
            S_STOP:  if (w_baud_done) w_state_next = w_not_empty ? S_START : S_IDLE;
                     else w_state_next = S_STOP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx              = 1'b1;
        is_transmitting = 1'b0;
        case (r_state)
            S_IDLE:  begin tx = 1'b1;                is_transmitting = 1'b0; end
            S_START: begin tx = 1'b0;                is_transmitting = 1'b1; end
            S_DATA:  begin tx = r_shift[r_bit_idx]; is_transmitting = 1'b1; end
            S_STOP:  begin tx = 1'b1;                is_transmitting = 1'b1; end
            default: begin tx = 1'b1;                is_transmitting = 1'b0; end
        endcase
    end

    // Baud counter restarts on every state change and between data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud    <= {BW{1'b0}};
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if ((w_state_next != r_state) || w_baud_done || (r_state == S_IDLE)) begin
                r_baud <= {BW{1'b0}};
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if (r_state != S_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {DEPTH_LOG2{1'b0}};
            r_rd_ptr   <= {DEPTH_LOG2{1'b0}};
            r_count    <= COUNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            else        r_wr_ptr <= r_wr_ptr;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            else        r_rd_ptr <= r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (transmit && full) r_overflow <= 1'b1;
            else                  r_overflow <= r_overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a frame-level reference model predicts every output
// each cycle, and a line receiver decodes tx and scores bytes against a queue.
module tb_uart_tx_queue;

    localparam int CPB   = 4;
    localparam int DL2   = 4;
    localparam int DEPTH = 2 ** DL2;
    localparam int FRAME = 10 * CPB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           transmit = 1'b0;
    logic [7:0]     tx_byte = 8'h00;
    logic           tx;
    logic           is_transmitting;
    logic           full;
    logic [DL2:0]   count;
    logic           overflow;

    int             n_checks = 0;
    int             n_fail   = 0;

    logic [7:0]     m_q[$];
    logic [7:0]     sb_q[$];
    int             m_f   = 0;
    logic [7:0]     m_cur = 8'h00;
    logic           m_ovf = 1'b0;

    uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .transmit(transmit), .tx_byte(tx_byte),
        .tx(tx), .is_transmitting(is_transmitting), .full(full),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame occupies FRAME cycles; the head pops when idle or on the last stop cycle.
    initial begin
        int  pre;
        logic pop;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete(); sb_q.delete(); m_f = 0; m_ovf = 1'b0;
            end else begin
                pre = m_q.size();
                pop = (pre > 0) && (m_f <= 1);
                if (transmit && (pre == DEPTH)) m_ovf = 1'b1;
                if (pop) begin
                    m_cur = m_q.pop_front();
                    m_f   = FRAME;
                end else if (m_f > 0) begin
                    m_f--;
                end
                if (transmit && (pre < DEPTH)) begin
                    m_q.push_back(tx_byte);
                    sb_q.push_back(tx_byte);
                end
            end
        end
    end

    // Cycle checker on the falling edge.
    initial begin
        int   el, bi;
        logic e_tx;
        forever begin
            @(negedge clk);
            if (m_f == 0) begin
                e_tx = 1'b1;
            end else begin
                el = FRAME - m_f;
                bi = el / CPB;
                if (bi == 0)      e_tx = 1'b0;
                else if (bi <= 8) e_tx = m_cur[bi-1];
                else              e_tx = 1'b1;
            end
            chk("tx", tx, e_tx);
            chk("is_transmitting", is_transmitting, m_f > 0);
            chk("count", count, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
        end
    end

    // Line receiver: decodes each frame from tx and scores it against sb_q.
    initial begin
        logic       rx_prev;
        logic       rx_abort;
        logic [8:0] rx_bits;
        logic [7:0] rx_exp;
        rx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && rx_prev && !tx) begin
                rx_abort = 1'b0;
                rx_bits  = 9'h000;
                for (int i = 0; i < 9; i++) begin
                    if (!rx_abort) begin
                        repeat (CPB) begin
                            @(negedge clk);
                            if (rst) rx_abort = 1'b1;
                        end
                        rx_bits[i] = tx;
                    end
                end
                if (!rx_abort) begin
                    chk("stop_bit", rx_bits[8], 1'b1);
                    chk("sb_nonempty", sb_q.size() > 0, 1'b1);
                    if (sb_q.size() > 0) begin
                        rx_exp = sb_q.pop_front();
                        chk("frame_byte", rx_bits[7:0], rx_exp);
                    end
                end
            end
            rx_prev = tx;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        transmit = 1'b1;
        tx_byte  = b;
        @(posedge clk);
        #1;
        transmit = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (((m_f != 0) || (m_q.size() != 0)) && (k < limit)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_in_time", k < limit, 1'b1);
        cyc(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic [9:0] a5_bits;
        int         k;
        logic       found;
        a5_bits = 10'b1101001010;

        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Single frame of 0xA5, line sampled every CPB cycles from the first start-bit cycle.
        push(8'hA5);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a5_line", tx, a5_bits[i]);
            if (i < 9) repeat (CPB - 1) @(negedge clk);
        end
        drain(200);

        // Back-to-back frames.
        push(8'h01); push(8'h02); push(8'h03);
        drain(400);

        // Overflow while the serializer is busy.
        push(8'h40);
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        chk("ovf_full_after_16", full, 1'b1);
        chk("ovf_count_16", count, 16);
        push(8'h20);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count_held", count, 16);
        drain(1500);

        // Push while full on the exact edge a stop bit completes.
        do_reset();
        push(8'h77);
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        found = 1'b0;
        k = 0;
        while (!found && (k < 100)) begin
            if ((m_f == 1) && (m_q.size() == DEPTH)) begin
                push(8'h99);
                found = 1'b1;
                chk("race_count", count, 15);
                chk("race_overflow", overflow, 1'b1);
                chk("race_full", full, 1'b0);
            end else begin
                cyc(1);
                k++;
            end
        end
        chk("race_edge_found", found, 1'b1);
        drain(1500);

        // Reset during the third data bit.
        do_reset();
        push(8'hFF); push(8'h00);
        k = 0;
        while ((m_f != 26) && (k < 100)) begin
            cyc(1);
            k++;
        end
        chk("reset_point_found", m_f == 26, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tx_high", tx, 1'b1);
        chk("rst_count_zero", count, 0);
        chk("rst_not_busy", is_transmitting, 1'b0);
        cyc(2);
        rst = 1'b0;
        cyc(60);
        push(8'h5A);
        drain(200);

        // Pointer wrap-around: 40 bytes in bursts of 10.
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 10; j++) push(8'(b * 10 + j));
            drain(600);
        end

        // Random traffic, sparse then dense enough to overflow.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) push(8'($urandom));
            else cyc(1);
        end
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 0) push(8'($urandom));
            else cyc(1);
        end
        drain(2500);

        cyc(5);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, SHALL set the clk cycles per serial bit (minimum 2).
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set FIFO depth to 2**DEPTH_LOG2 bytes (16 by default).
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge except reset.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 transmit  input  1  SHALL be a one-cycle enqueue strobe, sampled on the rising edge of clk.
REQ-006 tx_byte  input  8  SHALL be the byte to enqueue, valid when transmit=1.
REQ-007 tx  output  1  SHALL be the serial line: idle high, 8N1 framing, LSB first.
REQ-008 is_transmitting  output  1  SHALL be high whenever a frame (start, data or stop bit) is on tx.
REQ-009 full  output  1  SHALL be high when count equals 2**DEPTH_LOG2.
REQ-010 count  output  DEPTH_LOG2+1  SHALL be the number of bytes queued, excluding the byte being shifted.
REQ-011 overflow  output  1  SHALL be a sticky flag set when a byte is dropped; it is cleared only by rst.

Function
REQ-012 Enqueue: transmit=1 with full=0 SHALL write tx_byte at the write pointer and advance the pointer mod 2**DEPTH_LOG2.
REQ-013 Enqueue with full=1 SHALL drop the byte, leave FIFO contents and pointers unchanged, and set overflow.
REQ-014 The full decision SHALL use the pre-edge count; a push while full is dropped even if a pop occurs on the same edge.
REQ-015 Simultaneous push (not full) and pop SHALL leave count unchanged and both pointers advanced.
REQ-016 The serializer SHALL have four states: IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1 and is_transmitting=0; if count>0, the next edge SHALL pop the head byte into the shift register and enter START.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-019 DATA: tx=shift[index] for CLKS_PER_BIT cycles per bit, for indices 0..7, then enter STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then: if count>0, pop and enter START on the same edge (back-to-back frames, no idle gap); else enter IDLE.
REQ-021 Latency: a transmit sampled at edge k into an empty queue with the serializer in IDLE SHALL drive tx low from edge k+1.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1, reset to 0 on every state change, and wrap without drift.
REQ-023 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-024 Enqueue SHALL proceed independently of serializer state; FIFO order SHALL be preserved exactly.

Reset
REQ-025 While rst=1, asynchronously: tx=1, is_transmitting=0, state=IDLE, count=0, pointers=0, full=0, overflow=0, baud counter=0.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately (tx high) and discard all queued bytes.
REQ-027 After rst deasserts, the first enqueue SHALL behave per REQ-021.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=4)
REQ-028 Single frame: push 0xA5 -> tx samples every 4 cycles are 0,1,0,1,0,0,1,0,1,1; is_transmitting is high for exactly 40 cycles.
REQ-029 Back-to-back: push 0x01, 0x02, 0x03 on consecutive cycles -> three frames with no idle gap (120 cycles total), in order; count goes 1,2,... and reaches 0 when the third byte pops.
REQ-030 Overflow: with the serializer busy, push 17 bytes 0x10..0x20 on consecutive cycles -> full=1 after 16 pushes, 0x20 is dropped, overflow=1, and tx emits 0x10..0x1F in order.
REQ-031 Full push/pop race: push while full=1 on the exact edge a STOP completes -> pushed byte dropped, overflow=1, count=15.
REQ-032 Mid-frame reset: push 0xFF and 0x00, assert rst during the 3rd data bit -> tx=1 immediately, count=0, no further frame after release.
REQ-033 Wrap-around: push and drain 40 bytes 0x00..0x27 in bursts of 10 -> output order matches and pointers wrap with no corruption.
